// File: rtl/nes_irq_pkg.sv
// nes_irq_pkg: shared constants, id sizing helper and id type for the NES interrupt controller.
package nes_irq_pkg;
   localparam int MAX_SRC = 16;
   localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'hFFE0;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [id_width(MAX_SRC)-1:0] irqId_t;
endpackage

// File: rtl/nes_irq_prio_enc.sv
// nes_irq_prio_enc: parametrised lowest-index-wins priority encoder with valid flag.
module nes_irq_prio_enc
   import nes_irq_pkg::*;
#(
   parameter int N = 4,
   parameter int W = id_width(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] winner,
   output logic         valid
);
   always_comb begin
      winner = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) winner = W'(i);
      valid = |req;
   end
endmodule

// File: rtl/nes_irq_ctrl.sv
// nes_irq_ctrl: edge/level, maskable/non-maskable interrupt controller with fixed-priority vectoring.
// Optional NES_IRQ_SYNC_EN adds a 2-flop input synchroniser ahead of detection.
module nes_irq_ctrl
   import nes_irq_pkg::*;
#(
   parameter int                  NUM_SRC     = 4,
   parameter logic [NUM_SRC-1:0]  EDGE_MASK   = NUM_SRC'(1),
   parameter logic [NUM_SRC-1:0]  NMI_MASK    = NUM_SRC'(1),
   parameter logic [15:0]         VECTOR_BASE = DEFAULT_VECTOR_BASE
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ce,
   input  logic [NUM_SRC-1:0]            src,
   input  logic                          i_flag,
   input  logic                          en_we,
   input  logic [NUM_SRC-1:0]            en_wdata,
   input  logic                          ack,
   output logic                          irq_req,
   output logic [id_width(NUM_SRC)-1:0]  vec_id,
   output logic [15:0]                   vec_addr,
   output logic [NUM_SRC-1:0]            pending
);
   localparam int IdW = id_width(NUM_SRC);

   if (NUM_SRC < 1 || NUM_SRC > MAX_SRC) begin : gBadNum
      $error("nes_irq_ctrl: NUM_SRC out of range 1..16");
   end
   if (int'(VECTOR_BASE) + 2 * NUM_SRC - 1 > 32'hFFFF) begin : gBadBase
      $error("nes_irq_ctrl: vector table overflows 16-bit address space");
   end

   logic [NUM_SRC-1:0] srcS, last, enable, eligible, edgeSet, clrMask, nextPending;
   logic [IdW-1:0]     winner;
   logic               valid;

`ifdef NES_IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1, sync2;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= src;
         sync2 <= sync1;
      end
   end
   assign srcS = sync2;
`else
   assign srcS = src;
`endif

   assign eligible = pending & enable & (NMI_MASK | {NUM_SRC{~i_flag}});

   nes_irq_prio_enc #(.N(NUM_SRC), .W(IdW)) uPrio (
      .req    (eligible),
      .winner (winner),
      .valid  (valid)
   );

   assign irq_req  = valid;
   assign vec_addr = VECTOR_BASE + 16'({vec_id, 1'b0});

   // A new edge on the acknowledged source outranks the ack clear so it is not lost.
   always_comb begin
      edgeSet     = srcS & ~last;
      clrMask     = (ack && irq_req) ? ((NUM_SRC'(1) << winner) & EDGE_MASK) : '0;
      nextPending = (EDGE_MASK & (edgeSet | (pending & ~clrMask))) | (~EDGE_MASK & srcS);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         enable  <= '1;
         last    <= '1;
         vec_id  <= '0;
      end else if (ce) begin
         pending <= nextPending;
         last    <= srcS;
         if (en_we) enable <= en_wdata;
         if (ack && irq_req) vec_id <= winner;
      end
   end
endmodule

// File: tb/tb_nes_irq_ctrl.sv
// tb_nes_irq_ctrl: directed self-checking bench; sources 0,1 edge, 2,3 level, only source 0 non-maskable.
module tb_nes_irq_ctrl;
   logic       clk = 1'b0;
   logic       reset_n, ce, i_flag, en_we, ack;
   logic [3:0] src, en_wdata, pending;
   logic       irq_req;
   logic [1:0] vec_id;
   logic [15:0] vec_addr;
   int vectors = 0;
   int miscompares = 0;

   nes_irq_ctrl #(.NUM_SRC(4), .EDGE_MASK(4'b0011), .NMI_MASK(4'b0001), .VECTOR_BASE(16'hFFE0)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .src(src), .i_flag(i_flag),
      .en_we(en_we), .en_wdata(en_wdata), .ack(ack), .irq_req(irq_req),
      .vec_id(vec_id), .vec_addr(vec_addr), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ce = 1'b1; src = 4'b0001; i_flag = 1'b1;
      en_we = 1'b0; en_wdata = 4'b0000; ack = 1'b0;
      #1;
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pending got %b expected 0000", pending); end
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b expected 0", irq_req); end
      vectors++; if (vec_addr !== 16'hFFE0) begin miscompares++; $display("FAIL reset_vec_addr got %h expected ffe0", vec_addr); end
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL held_high_no_edge got %b expected 0000", pending); end
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL held_high_irq got %b expected 0", irq_req); end
      src = 4'b0000; tick();
      src = 4'b0001; tick();
      vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL edge0_pending got %b expected 0001", pending); end
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL edge0_irq got %b expected 1", irq_req); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL edge0_ack_clear got %b expected 0000", pending); end
      src = 4'b0000; tick();
   endtask

   task automatic test_mask();
      i_flag = 1'b1; src = 4'b1000; tick();
      vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL level3_pending got %b expected 1000", pending); end
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL level3_masked got %b expected 0", irq_req); end
      i_flag = 1'b0; #1;
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL level3_unmasked got %b expected 1", irq_req); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (vec_id !== 2'd3) begin miscompares++; $display("FAIL level3_vec_id got %0d expected 3", vec_id); end
      vectors++; if (vec_addr !== 16'hFFE6) begin miscompares++; $display("FAIL level3_vec_addr got %h expected ffe6", vec_addr); end
      vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL level3_not_cleared got %b expected 1000", pending); end
      src = 4'b0000; tick();
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL level3_follows_src got %b expected 0000", pending); end
   endtask

   task automatic test_priority();
      i_flag = 1'b0; src = 4'b0110; tick();
      vectors++; if (pending !== 4'b0110) begin miscompares++; $display("FAIL prio_pending got %b expected 0110", pending); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (vec_id !== 2'd1) begin miscompares++; $display("FAIL prio_first_id got %0d expected 1", vec_id); end
      vectors++; if (vec_addr !== 16'hFFE2) begin miscompares++; $display("FAIL prio_first_addr got %h expected ffe2", vec_addr); end
      vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL prio_edge1_cleared got %b expected 0100", pending); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (vec_id !== 2'd2) begin miscompares++; $display("FAIL prio_second_id got %0d expected 2", vec_id); end
      vectors++; if (vec_addr !== 16'hFFE4) begin miscompares++; $display("FAIL prio_second_addr got %h expected ffe4", vec_addr); end
      src = 4'b0000; tick();
   endtask

   task automatic test_spurious_ack();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL spurious_idle got %b expected 0", irq_req); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (vec_id !== 2'd2) begin miscompares++; $display("FAIL spurious_vec_id got %0d expected 2", vec_id); end
   endtask

   task automatic test_ack_edge_collision();
      src = 4'b0001; tick();
      src = 4'b0000; tick();
      vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL coll_pre_pending got %b expected 0001", pending); end
      src = 4'b0001; ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (vec_id !== 2'd0) begin miscompares++; $display("FAIL coll_vec_id got %0d expected 0", vec_id); end
      vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL coll_edge_kept got %b expected 0001", pending); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL coll_second_ack got %b expected 0000", pending); end
   endtask

   task automatic test_ce_gate();
      src = 4'b0000; tick();
      ce = 1'b0; src = 4'b0001; tick();
      src = 4'b0000; tick();
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL ce_hold_pending got %b expected 0000", pending); end
      ce = 1'b1; tick();
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL ce_pulse_lost got %b expected 0000", pending); end
   endtask

   task automatic test_enable();
      en_we = 1'b1; en_wdata = 4'b1110; tick(); en_we = 1'b0;
      src = 4'b0001; tick();
      vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL en_latch_disabled got %b expected 0001", pending); end
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL en_disabled_irq got %b expected 0", irq_req); end
      en_we = 1'b1; en_wdata = 4'b1111; tick(); en_we = 1'b0;
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL en_reenabled_irq got %b expected 1", irq_req); end
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL en_ack_clear got %b expected 0000", pending); end
      src = 4'b0000; tick();
   endtask

   task automatic test_async_reset();
      src = 4'b0100; tick();
      ack = 1'b1; tick(); ack = 1'b0;
      vectors++; if (vec_id !== 2'd2) begin miscompares++; $display("FAIL areset_pre_id got %0d expected 2", vec_id); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (vec_id !== 2'd0) begin miscompares++; $display("FAIL areset_vec_id got %0d expected 0", vec_id); end
      vectors++; if (vec_addr !== 16'hFFE0) begin miscompares++; $display("FAIL areset_vec_addr got %h expected ffe0", vec_addr); end
      vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL areset_pending got %b expected 0000", pending); end
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL areset_irq got %b expected 0", irq_req); end
      src = 4'b0000; tick();
      reset_n = 1'b1; tick();
   endtask

   initial begin
      test_reset();
      test_mask();
      test_priority();
      test_spurious_ack();
      test_ack_edge_collision();
      test_ce_gate();
      test_enable();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
